// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a programmed value down to zero and pulses done.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to keep running and reload from the reload register at zero.
module down_counter_timer #(
  parameter int WIDTH        = 4,
  parameter int DEFAULT_LOAD = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= DEFAULT_LOAD[WIDTH-1:0];
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (load) begin
      state_q  <= IDLE;
      count_q  <= load_value;
      reload_q <= load_value;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (count_q == ZERO) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (pause) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else if (count_q == ONE) begin
              // The starting edge already counts, so a value of 1 finishes immediately.
              count_q <= ZERO;
              done_q  <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              state_q <= RUN;
              busy_q  <= 1'b1;
`else
              state_q <= DONE;
`endif
            end else begin
              count_q <= count_q - ONE;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            done_q <= 1'b0;
          end else if (count_q > ONE) begin
            count_q <= count_q - ONE;
            done_q  <= 1'b0;
          end else if (count_q == ONE) begin
            count_q <= ZERO;
            done_q  <= 1'b1;
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
            state_q <= DONE;
            busy_q  <= 1'b0;
`endif
          end else begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            // Zero in RUN is the reload slot; a zero reload keeps done asserted.
            count_q <= reload_q;
            done_q  <= (reload_q == ZERO);
`else
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`endif
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            if (reload_q == ZERO) begin
              done_q <= 1'b1;
            end else begin
              count_q <= reload_q;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer; observes {count, busy, done}
// one time unit after each rising edge.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       start;
  logic       pause;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  logic [5:0] obs;
  logic [5:0] exp;

  down_counter_timer #(.WIDTH(4), .DEFAULT_LOAD(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    obs = {count, busy, done};
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; load_value = 4'd0; start = 1'b0; pause = 1'b0;
    step(); step();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
    reset = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_start_zero got=%h exp=%h", obs, exp); end
    step();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_done_fall got=%h exp=%h", obs, exp); end
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd15, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_default_reload got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_countdown();
    load = 1'b1; load_value = 4'd5; step(); load = 1'b0;
    exp = {4'd5, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL cd_load got=%h exp=%h", obs, exp); end
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd4, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL cd_start got=%h exp=%h", obs, exp); end
    for (int k = 3; k >= 1; k--) begin
      step();
      exp = {k[3:0], 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL cd_step%0d got=%h exp=%h", k, obs, exp); end
    end
    step();
    exp = {4'd0, AUTO, 1'b1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL cd_zero got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_pause();
    int n;
    load = 1'b1; load_value = 4'd6; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 1;
    step(); n++;
    exp = {4'd4, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL pause_pre got=%h exp=%h", obs, exp); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); n++;
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL pause_hold%0d got=%h exp=%h", k, obs, exp); end
    end
    pause = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      step(); n++;
    end
    checks++;
    if (n !== 9) begin failures++; $display("FAIL pause_latency got=%0d exp=%0d", n, 9); end
  endtask

  task automatic test_restart();
    step();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rs_done_idle got=%h exp=%h", obs, exp); end
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd6, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rs_reload got=%h exp=%h", obs, exp); end
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd5, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rs_start_in_run got=%h exp=%h", obs, exp); end
    load = 1'b1; load_value = 4'd3; step(); load = 1'b0;
    exp = {4'd3, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rs_load_mid_run got=%h exp=%h", obs, exp); end
    step();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rs_idle_hold got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_value = 4'd3; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd2, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rm_pre got=%h exp=%h", obs, exp); end
    reset = 1'b0; step(); reset = 1'b1;
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rm_abort got=%h exp=%h", obs, exp); end
    start = 1'b1; step(); step(); start = 1'b0;
    exp = {4'd15, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rm_reload_default got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_load_start();
    load = 1'b1; start = 1'b1; load_value = 4'd7; step(); load = 1'b0; start = 1'b0;
    exp = {4'd7, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL ls_load_wins got=%h exp=%h", obs, exp); end
    step();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL ls_stays_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_start_one();
    load = 1'b1; load_value = 4'd1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd0, AUTO, 1'b1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL one_done got=%h exp=%h", obs, exp); end
    step();
    exp = {3'd0, AUTO, AUTO, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL one_after got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_zero_reload();
    load = 1'b1; load_value = 4'd0; step(); load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; step(); start = 1'b0;
      exp = {4'd0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL zr_pulse%0d got=%h exp=%h", k, obs, exp); end
      step();
      exp = {4'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL zr_fall%0d got=%h exp=%h", k, obs, exp); end
    end
  endtask

  task automatic test_auto_reload();
    logic [5:0] seq [0:5];
    seq[0] = {4'd1, 1'b1, 1'b0};
    seq[1] = {4'd0, 1'b1, 1'b1};
    seq[2] = {4'd2, 1'b1, 1'b0};
    seq[3] = {4'd1, 1'b1, 1'b0};
    seq[4] = {4'd0, 1'b1, 1'b1};
    seq[5] = {4'd2, 1'b1, 1'b0};
    load = 1'b1; load_value = 4'd2; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      exp = seq[k];
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL ar_seq%0d got=%h exp=%h", k, obs, exp); end
    end
    load = 1'b1; load_value = 4'd0; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp = {4'd0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL ar_zero_pulse got=%h exp=%h", obs, exp); end
    step();
    exp = {4'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL ar_zero_single got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_countdown();
    test_pause();
    if (AUTO) begin
      test_auto_reload();
    end else begin
      test_restart();
      test_zero_reload();
    end
    test_reset_mid();
    test_load_start();
    test_start_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
